// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: ALU opcodes and operand-select encodings.
package cpu_pkg;

  localparam logic [3:0] ALU_AND          = 4'b0000;
  localparam logic [3:0] ALU_OR           = 4'b0001;
  localparam logic [3:0] ALU_ADD          = 4'b0010;
  localparam logic [3:0] ALU_LF_16        = 4'b0011;
  localparam logic [3:0] ALU_UNSIGNED_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL          = 4'b0101;
  localparam logic [3:0] ALU_SUB          = 4'b0110;
  localparam logic [3:0] ALU_SIGNED_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR          = 4'b1001;
  localparam logic [3:0] ALU_XOR          = 4'b1010;
  localparam logic [3:0] ALU_SRA          = 4'b1011;
  localparam logic [3:0] ALU_SRL          = 4'b1100;

  // Operand A select; the unused code 3 yields zero.
  typedef enum logic [1:0] {
    SRC_A_RS   = 2'd0,
    SRC_A_SA   = 2'd1,
    SRC_A_PC   = 2'd2,
    SRC_A_ZERO = 2'd3
  } src_a_e;

  // Operand B select; constant 8 is the link offset for jal/jalr.
  typedef enum logic [1:0] {
    SRC_B_RT    = 2'd0,
    SRC_B_SIMM  = 2'd1,
    SRC_B_ZIMM  = 2'd2,
    SRC_B_CONST8 = 2'd3
  } src_b_e;

endpackage

// File: rtl/operand_fwd.sv
// Resolves one source operand: $0, then EX-stage result, then MEM-stage result, then register file.
module operand_fwd #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            src_reg,
  input  logic [DATA_WIDTH-1:0] rf_val,
  input  logic                  ex_en,
  input  logic [4:0]            ex_dest,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  mem_we,
  input  logic [4:0]            mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_result,
  output logic [DATA_WIDTH-1:0] fwd_val
);

  // Youngest producer wins; $0 is hardwired regardless of any pending write to it.
  always_comb begin
    fwd_val = rf_val;
    if (src_reg == 5'd0)
      fwd_val = '0;
    else if (ex_en && ex_dest == src_reg)
      fwd_val = ex_result;
    else if (mem_we && mem_dest == src_reg)
      fwd_val = mem_result;
  end

endmodule

// File: rtl/id_exe_stage.sv
// Decode-to-execute stage register: forwarding, ALU operand selection, handshake, load-use bubbles and flush.
module id_exe_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic [DATA_WIDTH-1:0] id_rs_val,
  input  logic [DATA_WIDTH-1:0] id_rt_val,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [15:0]           id_imm,
  input  logic [4:0]            id_sa,
  input  logic [3:0]            id_alu_op,
  input  logic [1:0]            id_src_a,
  input  logic [1:0]            id_src_b,
  input  logic [4:0]            id_dest,
  input  logic                  id_reg_we,
  input  logic                  id_mem_rd,
  input  logic                  id_mem_wr,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  mem_we,
  input  logic [4:0]            mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [4:0]            out_dest,
  output logic                  out_reg_we,
  output logic                  out_mem_rd,
  output logic                  out_mem_wr
);

  logic                  allowin;
  logic                  hazard;
  logic                  ex_fwd_en;
  logic [DATA_WIDTH-1:0] rs_fwd;
  logic [DATA_WIDTH-1:0] rt_fwd;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;

  assign allowin = !out_valid || out_ready;

  // A held load's data is not available until MEM, so a dependent instruction must wait one cycle.
  assign hazard = out_valid && out_mem_rd && (out_dest != 5'd0) &&
                  ((id_uses_rs && id_rs == out_dest) || (id_uses_rt && id_rt == out_dest));

  assign id_ready = allowin && !hazard && !flush;

  // The held result is only forwardable when it is an ALU result, not a pending load.
  assign ex_fwd_en = out_valid && out_reg_we && !out_mem_rd;

  operand_fwd #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs (
    .src_reg    (id_rs),
    .rf_val     (id_rs_val),
    .ex_en      (ex_fwd_en),
    .ex_dest    (out_dest),
    .ex_result  (ex_result),
    .mem_we     (mem_we),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .fwd_val    (rs_fwd)
  );

  operand_fwd #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rt (
    .src_reg    (id_rt),
    .rf_val     (id_rt_val),
    .ex_en      (ex_fwd_en),
    .ex_dest    (out_dest),
    .ex_result  (ex_result),
    .mem_we     (mem_we),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .fwd_val    (rt_fwd)
  );

  // ALU operand selection from forwarded registers, immediates, shift amount and PC.
  always_comb begin
    opnd_a = '0;
    case (src_a_e'(id_src_a))
      SRC_A_RS: opnd_a = rs_fwd;
      SRC_A_SA: opnd_a = {{(DATA_WIDTH-5){1'b0}}, id_sa};
      SRC_A_PC: opnd_a = id_pc;
      default:  opnd_a = '0;
    endcase

    opnd_b = '0;
    case (src_b_e'(id_src_b))
      SRC_B_RT:     opnd_b = rt_fwd;
      SRC_B_SIMM:   opnd_b = {{(DATA_WIDTH-16){id_imm[15]}}, id_imm};
      SRC_B_ZIMM:   opnd_b = {{(DATA_WIDTH-16){1'b0}}, id_imm};
      default:      opnd_b = DATA_WIDTH'(8);
    endcase
  end

  // Stage register: reset, then flush, then accept / bubble, otherwise hold for downstream.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      out_pc     <= '0;
      store_data <= '0;
      out_dest   <= '0;
      out_reg_we <= 1'b0;
      out_mem_rd <= 1'b0;
      out_mem_wr <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (allowin) begin
      if (id_valid && !hazard) begin
        out_valid  <= 1'b1;
        alu_a      <= opnd_a;
        alu_b      <= opnd_b;
        alu_op     <= id_alu_op;
        out_pc     <= id_pc;
        store_data <= rt_fwd;
        out_dest   <= id_dest;
        out_reg_we <= id_reg_we;
        out_mem_rd <= id_mem_rd;
        out_mem_wr <= id_mem_wr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/id_exe_stage.md
# id_exe_stage

Decode-to-execute pipeline stage of the 5-stage MIPS core. Sits directly upstream of the ALU. It resolves source operands through EX/MEM forwarding, selects ALU A/B inputs, and latches them with the 4-bit ALUop into the stage register that drives the ALU. It also owns the valid/allowin handshake, load-use stall bubbles and flush.

## Interface
- `DATA_WIDTH`, 32, datapath width
- `clk` in 1 — single clock, rising edge
- `resetn` in 1 — synchronous, active-low reset
- `id_valid` in 1 — decode holds an instruction
- `id_ready` out 1 — stage accepts decode's instruction this cycle
- `id_pc` in 32 — instruction PC
- `id_rs`, `id_rt` in 5 each — source register numbers
- `id_rs_val`, `id_rt_val` in 32 each — register-file read data
- `id_uses_rs`, `id_uses_rt` in 1 each — operand is actually read
- `id_imm` in 16 — immediate
- `id_sa` in 5 — shift amount
- `id_alu_op` in 4 — ALU opcode, ALU encoding
- `id_src_a` in 2 — 0 rs, 1 zero-extended sa, 2 pc
- `id_src_b` in 2 — 0 rt, 1 sign-ext imm, 2 zero-ext imm, 3 constant 8
- `id_dest` in 5 — destination register
- `id_reg_we`, `id_mem_rd`, `id_mem_wr` in 1 each — writeback / load / store
- `ex_result` in 32 — ALU Result of the instruction currently held here
- `mem_we` in 1, `mem_dest` in 5, `mem_result` in 32 — MEM-stage writeback
- `flush` in 1 — kill held and incoming instruction
- `out_ready` in 1 — downstream consumes current contents
- `out_valid` out 1; `alu_a`, `alu_b` out 32; `alu_op` out 4; `out_pc` out 32; `store_data` out 32; `out_dest` out 5; `out_reg_we`, `out_mem_rd`, `out_mem_wr` out 1

## Operation
- `allowin` = !out_valid || out_ready.
- Hazard: out_valid && out_mem_rd && out_dest≠0 && ((id_uses_rs && id_rs==out_dest) || (id_uses_rt && id_rt==out_dest)).
- `id_ready` = allowin && !hazard && !flush (combinational).
- Register update, in priority order:
  - !resetn: all outputs are 0.
  - flush: out_valid is 0. Data registers are don't-care.
  - allowin && id_valid && !hazard: load all fields; out_valid is 1.
  - allowin otherwise: out_valid is 0 (bubble). Data registers are unchanged.
  - !allowin: hold everything.
- Forwarding per source (rs, rt), resolved before the register:
  - If register is 0: value 0.
  - Else if out_valid && out_reg_we && !out_mem_rd && out_dest==reg: ex_result.
  - Else if mem_we && mem_dest==reg: mem_result.
  - Else: register-file value.
- Operand A: fwd rs / {27'b0, sa} / pc. Encoding 3 gives 0.
- Operand B: fwd rt / sign-ext imm / {16'b0, imm} / 32'd8.
- store_data = forwarded rt.
- alu_op is passed through unchanged. Link instructions arrive from decode with src_a=2, src_b=3, alu_op=4'b0010.

## Timing
- One-cycle latency: an instruction accepted at edge N is presented to the ALU after edge N.
- Each load-use hazard inserts exactly one bubble. The dependent instruction is accepted on the following allowin cycle, with the loaded value arriving through the MEM forward path.
- Stalled downstream (!out_ready with out_valid=1): all outputs stable. id_ready is 0.
- Flush overrides a simultaneous accept or hold.
- resetn low mid-stall clears out_valid on that edge.

## Structure
- Shared package `cpu_pkg` holds:
  - ALUop constants: AND 0000, OR 0001, ADD 0010, LF_16 0011, UNSIGNED_SLT 0100, SLL 0101, SUB 0110, SIGNED_SLT 0111, NOR 1001, XOR 1010, SRA 1011, SRL 1100.
  - SRC_A / SRC_B select encodings.
- One sub-module `operand_fwd` performs forwarding for a single source. It is instantiated twice, for rs and rt.
- The stage register and handshake logic live in the top module.

## Test plan
- Reset, with resetn low for 2 cycles: out_valid=0, alu_a=0, alu_op=0. id_ready=1 once resetn=1.
- `addiu $3,$2,-1`:
  - Stimulus: id_rs_val=5, src_b=1, imm=16'hFFFF, alu_op=0010.
  - Required: next cycle alu_a=5, alu_b=32'hFFFF_FFFF, out_valid=1.
- EX forwarding, then MEM:
  - Stimulus: held instruction writes $4, ex_result=32'h1234. Next instruction reads rs=4 with stale id_rs_val=0.
  - Required: alu_a=32'h1234.
  - With the EX match absent and mem_dest=4, mem_result=7: alu_a=7.
- Load-use:
  - Stimulus: held `lw $5`; incoming instruction reads $5.
  - Required: id_ready=0; one cycle with out_valid=0; then accepted with the value from mem_result.
- Backpressure and flush:
  - Stimulus: out_ready=0 for 3 cycles.
  - Required: outputs unchanged and id_ready=0. Asserting flush during the stall gives out_valid=0 next cycle.
- Register 0 and link:
  - Stimulus: rs=0 while EX writes $0 with ex_result=9.
  - Required: alu_a=0.
  - `jal` at pc=32'h100: alu_a=32'h100, alu_b=8.
